// File: rtl/wb_arbiter.sv
// Writeback arbiter: merges load responses and queued ALU results onto one register-file write port.
// Optional macro WB_FWD_EN adds combinational forwarding outputs for the selected write.
module wb_arbiter #(
  parameter int unsigned XLEN   = 32,
  parameter int unsigned QDEPTH = 2
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            alu_valid,
  output logic            alu_ready,
  input  logic [4:0]      alu_rd,
  input  logic [XLEN-1:0] alu_data,
  input  logic            ld_valid,
  input  logic [4:0]      ld_rd,
  input  logic [2:0]      ld_funct3,
  input  logic [1:0]      ld_addrLo,
  input  logic [XLEN-1:0] ld_rdata,
  output logic [4:0]      wrReg,
  output logic [XLEN-1:0] wrData,
  output logic            writeEnable,
  output logic            mem_writeEnable,
  output logic            busy
`ifdef WB_FWD_EN
  ,
  output logic            fwdValid,
  output logic [4:0]      fwdReg,
  output logic [XLEN-1:0] fwdData
`endif
);

  localparam int unsigned PW = (QDEPTH > 1) ? $clog2(QDEPTH) : 1;
  localparam int unsigned CW = $clog2(QDEPTH + 1);

  logic [4:0]      r_q_rd   [QDEPTH];
  logic [XLEN-1:0] r_q_data [QDEPTH];
  logic [PW-1:0]   r_wr_ptr;
  logic [PW-1:0]   r_rd_ptr;
  logic [CW-1:0]   r_count;

  logic            w_alu_ready;
  logic            w_q_nempty;
  logic            w_direct;
  logic            w_push;
  logic            w_pop;
  logic [7:0]      w_byte;
  logic [15:0]     w_half;
  logic [XLEN-1:0] w_ld_fmt;
  logic            w_sel_valid;
  logic            w_sel_is_ld;
  logic [4:0]      w_sel_rd;
  logic [XLEN-1:0] w_sel_data;

  assign w_alu_ready = (r_count < CW'(QDEPTH));
  assign w_q_nempty  = (r_count != '0);
  assign w_pop       = !ld_valid && w_q_nempty;
  assign w_direct    = !ld_valid && !w_q_nempty && alu_valid;
  assign w_push      = alu_valid && w_alu_ready && !w_direct;

  assign alu_ready = w_alu_ready;
  assign busy      = w_q_nempty;

  // Load alignment and extension; unknown funct3 codes fall back to a full word
  assign w_byte = ld_rdata[{ld_addrLo, 3'b000} +: 8];
  assign w_half = ld_addrLo[1] ? ld_rdata[31:16] : ld_rdata[15:0];

  always_comb begin
    w_ld_fmt = ld_rdata;
    case (ld_funct3)
      3'b000:  w_ld_fmt = {{(XLEN-8){w_byte[7]}}, w_byte};
      3'b001:  w_ld_fmt = {{(XLEN-16){w_half[15]}}, w_half};
      3'b100:  w_ld_fmt = {{(XLEN-8){1'b0}}, w_byte};
      3'b101:  w_ld_fmt = {{(XLEN-16){1'b0}}, w_half};
      default: w_ld_fmt = ld_rdata;
    endcase
  end

  // Source priority: load, then queue head, then direct ALU when the queue is empty
  always_comb begin
    w_sel_valid = 1'b0;
    w_sel_is_ld = 1'b0;
    w_sel_rd    = '0;
    w_sel_data  = '0;
    if (ld_valid) begin
      w_sel_valid = 1'b1;
      w_sel_is_ld = 1'b1;
      w_sel_rd    = ld_rd;
      w_sel_data  = w_ld_fmt;
    end else if (w_q_nempty) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = r_q_rd[r_rd_ptr];
      w_sel_data  = r_q_data[r_rd_ptr];
    end else if (alu_valid) begin
      w_sel_valid = 1'b1;
      w_sel_rd    = alu_rd;
      w_sel_data  = alu_data;
    end
  end

`ifdef WB_FWD_EN
  assign fwdValid = w_sel_valid && (w_sel_rd != 5'd0);
  assign fwdReg   = w_sel_rd;
  assign fwdData  = w_sel_data;
`endif

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_q_rd[r_wr_ptr]   <= alu_rd;
      r_q_data[r_wr_ptr] <= alu_data;
    end
  end

  // Pointers wrap naturally because QDEPTH is a power of two
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + PW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Writes to x0 are consumed without touching the write port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wrReg           <= '0;
      wrData          <= '0;
      writeEnable     <= 1'b0;
      mem_writeEnable <= 1'b0;
    end else begin
      writeEnable     <= 1'b0;
      mem_writeEnable <= 1'b0;
      if (w_sel_valid && (w_sel_rd != 5'd0)) begin
        wrReg           <= w_sel_rd;
        wrData          <= w_sel_data;
        writeEnable     <= !w_sel_is_ld;
        mem_writeEnable <= w_sel_is_ld;
      end
    end
  end

endmodule

// File: tb/tb_wb_arbiter.sv
// Directed self-checking bench for wb_arbiter (default XLEN=32, QDEPTH=2).
module tb_wb_arbiter;

  logic        clk;
  logic        rst_n;
  logic        alu_valid;
  logic        alu_ready;
  logic [4:0]  alu_rd;
  logic [31:0] alu_data;
  logic        ld_valid;
  logic [4:0]  ld_rd;
  logic [2:0]  ld_funct3;
  logic [1:0]  ld_addrLo;
  logic [31:0] ld_rdata;
  logic [4:0]  wrReg;
  logic [31:0] wrData;
  logic        writeEnable;
  logic        mem_writeEnable;
  logic        busy;
`ifdef WB_FWD_EN
  logic        fwdValid;
  logic [4:0]  fwdReg;
  logic [31:0] fwdData;
`endif

  int checks;
  int failures;

  wb_arbiter dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .alu_valid       (alu_valid),
    .alu_ready       (alu_ready),
    .alu_rd          (alu_rd),
    .alu_data        (alu_data),
    .ld_valid        (ld_valid),
    .ld_rd           (ld_rd),
    .ld_funct3       (ld_funct3),
    .ld_addrLo       (ld_addrLo),
    .ld_rdata        (ld_rdata),
    .wrReg           (wrReg),
    .wrData          (wrData),
    .writeEnable     (writeEnable),
    .mem_writeEnable (mem_writeEnable),
    .busy            (busy)
`ifdef WB_FWD_EN
    ,
    .fwdValid        (fwdValid),
    .fwdReg          (fwdReg),
    .fwdData         (fwdData)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (rst_n) begin
      checks++;
      if (writeEnable && mem_writeEnable) begin
        failures++;
        $display("FAIL excl_enables: writeEnable=%0b mem_writeEnable=%0b, required not both 1", writeEnable, mem_writeEnable);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    alu_valid = 1'b0; alu_rd = '0; alu_data = '0;
    ld_valid = 1'b0; ld_rd = '0; ld_funct3 = '0; ld_addrLo = '0; ld_rdata = '0;
    #1;
    checks++; if (writeEnable !== 1'b0) begin failures++; $display("FAIL reset_we: got %0b want 0", writeEnable); end
    checks++; if (mem_writeEnable !== 1'b0) begin failures++; $display("FAIL reset_mwe: got %0b want 0", mem_writeEnable); end
    checks++; if (wrReg !== 5'd0) begin failures++; $display("FAIL reset_wrReg: got %0d want 0", wrReg); end
    checks++; if (wrData !== 32'd0) begin failures++; $display("FAIL reset_wrData: got %h want 0", wrData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %0b want 0", busy); end
    checks++; if (alu_ready !== 1'b1) begin failures++; $display("FAIL reset_ready: got %0b want 1", alu_ready); end
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_alu_direct();
    alu_valid = 1'b1; alu_rd = 5'd5; alu_data = 32'h0000_1234;
    #1;
`ifdef WB_FWD_EN
    checks++; if (fwdValid !== 1'b1 || fwdReg !== 5'd5 || fwdData !== 32'h1234) begin
      failures++; $display("FAIL fwd_direct: got v=%0b rd=%0d d=%h want 1 5 00001234", fwdValid, fwdReg, fwdData);
    end
`endif
    step();
    alu_valid = 1'b0;
    checks++; if (writeEnable !== 1'b1) begin failures++; $display("FAIL direct_we: got %0b want 1", writeEnable); end
    checks++; if (mem_writeEnable !== 1'b0) begin failures++; $display("FAIL direct_mwe: got %0b want 0", mem_writeEnable); end
    checks++; if (wrReg !== 5'd5) begin failures++; $display("FAIL direct_wrReg: got %0d want 5", wrReg); end
    checks++; if (wrData !== 32'h0000_1234) begin failures++; $display("FAIL direct_wrData: got %h want 00001234", wrData); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL direct_busy: got %0b want 0", busy); end
    step();
    checks++; if (writeEnable !== 1'b0) begin failures++; $display("FAIL idle_we: got %0b want 0", writeEnable); end
    checks++; if (wrData !== 32'h0000_1234) begin failures++; $display("FAIL idle_hold: got %h want 00001234", wrData); end
  endtask

  task automatic test_load_format();
    logic [2:0]  f3  [7];
    logic [1:0]  lo  [7];
    logic [31:0] raw [7];
    logic [31:0] exp [7];
    f3[0] = 3'b000; lo[0] = 2'd2; raw[0] = 32'h0080_0000; exp[0] = 32'hFFFF_FF80;
    f3[1] = 3'b101; lo[1] = 2'd2; raw[1] = 32'h8001_0000; exp[1] = 32'h0000_8001;
    f3[2] = 3'b001; lo[2] = 2'd0; raw[2] = 32'h1234_F00D; exp[2] = 32'hFFFF_F00D;
    f3[3] = 3'b100; lo[3] = 2'd3; raw[3] = 32'hA500_0000; exp[3] = 32'h0000_00A5;
    f3[4] = 3'b010; lo[4] = 2'd0; raw[4] = 32'hCAFE_BABE; exp[4] = 32'hCAFE_BABE;
    f3[5] = 3'b011; lo[5] = 2'd1; raw[5] = 32'h1357_9BDF; exp[5] = 32'h1357_9BDF;
    f3[6] = 3'b000; lo[6] = 2'd1; raw[6] = 32'h0000_7F00; exp[6] = 32'h0000_007F;
    for (int i = 0; i < 7; i++) begin
      ld_valid = 1'b1; ld_rd = 5'd3; ld_funct3 = f3[i]; ld_addrLo = lo[i]; ld_rdata = raw[i];
      step();
      checks++; if (mem_writeEnable !== 1'b1 || writeEnable !== 1'b0) begin
        failures++; $display("FAIL load%0d_en: got mwe=%0b we=%0b want 1 0", i, mem_writeEnable, writeEnable);
      end
      checks++; if (wrReg !== 5'd3) begin failures++; $display("FAIL load%0d_wrReg: got %0d want 3", i, wrReg); end
      checks++; if (wrData !== exp[i]) begin failures++; $display("FAIL load%0d_wrData: got %h want %h", i, wrData, exp[i]); end
    end
    ld_valid = 1'b0;
  endtask

  task automatic test_priority();
    for (int i = 0; i < 3; i++) begin
      ld_valid = 1'b1; ld_rd = 5'd2; ld_funct3 = 3'b010; ld_addrLo = 2'd0; ld_rdata = 32'h100 + 32'(i);
      alu_valid = 1'b1; alu_rd = 5'd7; alu_data = 32'hA0 + 32'(i);
      step();
      checks++; if (mem_writeEnable !== 1'b1 || wrReg !== 5'd2 || wrData !== 32'h100 + 32'(i)) begin
        failures++; $display("FAIL prio_load%0d: got mwe=%0b rd=%0d d=%h want 1 2 %h", i, mem_writeEnable, wrReg, wrData, 32'h100 + 32'(i));
      end
      checks++; if (alu_ready !== (i < 1)) begin failures++; $display("FAIL prio_ready%0d: got %0b want %0b", i, alu_ready, i < 1); end
      checks++; if (busy !== 1'b1) begin failures++; $display("FAIL prio_busy%0d: got %0b want 1", i, busy); end
    end
    // A2 was refused; it stays offered while the queue drains
    ld_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (i == 1) alu_valid = 1'b0;
      checks++; if (writeEnable !== 1'b1 || mem_writeEnable !== 1'b0 || wrReg !== 5'd7 || wrData !== 32'hA0 + 32'(i)) begin
        failures++; $display("FAIL drain%0d: got we=%0b mwe=%0b rd=%0d d=%h want 1 0 7 %h", i, writeEnable, mem_writeEnable, wrReg, wrData, 32'hA0 + 32'(i));
      end
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL drain_busy: got %0b want 0", busy); end
    step();
    checks++; if (writeEnable !== 1'b0 || wrData !== 32'hA2) begin
      failures++; $display("FAIL drain_idle: got we=%0b d=%h want 0 000000a2", writeEnable, wrData);
    end
  endtask

  task automatic test_rd_zero();
    alu_valid = 1'b1; alu_rd = 5'd0; alu_data = 32'h0000_DEAD;
    step();
    alu_valid = 1'b0;
    checks++; if (writeEnable !== 1'b0 || mem_writeEnable !== 1'b0) begin
      failures++; $display("FAIL rd0_alu_en: got we=%0b mwe=%0b want 0 0", writeEnable, mem_writeEnable);
    end
    checks++; if (wrData !== 32'hA2 || wrReg !== 5'd7) begin
      failures++; $display("FAIL rd0_alu_hold: got rd=%0d d=%h want 7 000000a2", wrReg, wrData);
    end
    ld_valid = 1'b1; ld_rd = 5'd0; ld_funct3 = 3'b010; ld_rdata = 32'h0000_BEEF;
    step();
    ld_valid = 1'b0;
    checks++; if (writeEnable !== 1'b0 || mem_writeEnable !== 1'b0 || wrData !== 32'hA2) begin
      failures++; $display("FAIL rd0_ld: got we=%0b mwe=%0b d=%h want 0 0 000000a2", writeEnable, mem_writeEnable, wrData);
    end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rd0_busy: got %0b want 0", busy); end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 2; i++) begin
      ld_valid = 1'b1; ld_rd = 5'd4; ld_funct3 = 3'b010; ld_addrLo = 2'd0; ld_rdata = 32'h55;
      alu_valid = 1'b1; alu_rd = 5'd9; alu_data = 32'hB0 + 32'(i);
      step();
    end
    checks++; if (busy !== 1'b1 || alu_ready !== 1'b0 || mem_writeEnable !== 1'b1) begin
      failures++; $display("FAIL fill: got busy=%0b ready=%0b mwe=%0b want 1 0 1", busy, alu_ready, mem_writeEnable);
    end
    ld_valid = 1'b0; alu_valid = 1'b0;
    #3;
    rst_n = 1'b0;
    #1;
    checks++; if (writeEnable !== 1'b0 || mem_writeEnable !== 1'b0) begin
      failures++; $display("FAIL rstmid_en: got we=%0b mwe=%0b want 0 0", writeEnable, mem_writeEnable);
    end
    checks++; if (busy !== 1'b0 || alu_ready !== 1'b1) begin
      failures++; $display("FAIL rstmid_q: got busy=%0b ready=%0b want 0 1", busy, alu_ready);
    end
    checks++; if (wrData !== 32'd0 || wrReg !== 5'd0) begin
      failures++; $display("FAIL rstmid_port: got rd=%0d d=%h want 0 0", wrReg, wrData);
    end
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++; if (writeEnable !== 1'b0 || mem_writeEnable !== 1'b0 || busy !== 1'b0 || wrData !== 32'd0) begin
        failures++; $display("FAIL post_rst%0d: got we=%0b mwe=%0b busy=%0b d=%h want 0 0 0 0", i, writeEnable, mem_writeEnable, busy, wrData);
      end
    end
  endtask

  initial begin
    checks = 0;
    failures = 0;
    test_reset();
    test_alu_direct();
    test_load_format();
    test_priority();
    test_rd_zero();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_arbiter.md
WB_ARBITER -- requirements
Module: wb_arbiter

Interface
REQ-001 SHALL have parameter XLEN, default 32, meaning register/data width.
REQ-002 SHALL have parameter QDEPTH, default 2, meaning ALU result queue entries (power of two, >=2).
REQ-003 SHALL have ports: clk  in  1  single clock, all state on rising edge.
REQ-004 SHALL have ports: rst_n  in  1  reset, asynchronous, active-low.
REQ-005 SHALL have ports: alu_valid  in  1  ALU result offered.
REQ-006 SHALL have ports: alu_ready  out  1  ALU result accepted this cycle.
REQ-007 SHALL have ports: alu_rd  in  5  and  alu_data  in  XLEN  destination register and result.
REQ-008 SHALL have ports: ld_valid  in  1  load response present (no backpressure; always accepted).
REQ-009 SHALL have ports: ld_rd  in  5,  ld_funct3  in  3,  ld_addrLo  in  2,  ld_rdata  in  XLEN  load destination, type, byte offset, raw word.
REQ-010 SHALL have ports: wrReg  out  5,  wrData  out  XLEN,  writeEnable  out  1,  mem_writeEnable  out  1  register-file write port, all registered.
REQ-011 SHALL have ports: busy  out  1  queue non-empty.

Function
REQ-012 SHALL issue at most one register-file write per cycle; writeEnable and mem_writeEnable SHALL never both be 1.
REQ-013 SHALL select source each cycle by priority: ld_valid, then queue head, then direct alu_valid (only when queue empty).
REQ-014 SHALL drive selected load on next edge as mem_writeEnable=1, writeEnable=0; selected ALU entry as writeEnable=1, mem_writeEnable=0 (latency 1 cycle).
REQ-015 SHALL assert alu_ready = (count < QDEPTH), independent of ld_valid.
REQ-016 SHALL push alu_rd/alu_data into queue when alu_valid && alu_ready and the direct ALU path is not selected.
REQ-017 SHALL keep ALU results in acceptance order; simultaneous push and pop SHALL leave count unchanged; pointers SHALL wrap modulo QDEPTH.
REQ-018 SHALL format load data: funct3 000 LB byte at ld_addrLo, sign-extended; 001 LH half at ld_addrLo[1], sign-extended; 010 LW; 100 LBU zero-extended; 101 LHU zero-extended; any other code SHALL be treated as LW.
REQ-019 SHALL consume but suppress writes with rd=0: both enables 0, wrReg/wrData unchanged.
REQ-020 SHALL hold wrReg/wrData at last written value in cycles with no write; enables SHALL drop to 0.
REQ-021 SHALL assert busy when count != 0.

Reset
REQ-022 SHALL on rst_n=0 immediately clear writeEnable, mem_writeEnable, wrReg, wrData, queue pointers and count to 0; alu_ready SHALL read 1 after reset.
REQ-023 SHALL discard queued ALU results on reset mid-operation; no write SHALL follow reset release until new input.

Configuration
REQ-024 SHALL, with macro WB_FWD_EN defined, add outputs fwdValid (1), fwdReg (5), fwdData (XLEN), combinationally equal to this cycle's selected write (fwdValid=0 when rd=0 or none selected).
REQ-025 SHALL, without WB_FWD_EN, omit those ports; all other behaviour identical.

Verification
REQ-026 SHALL cover: alu_valid, rd=5, data=0x1234 into empty block -> next cycle writeEnable=1, wrReg=5, wrData=0x1234.
REQ-027 SHALL cover: ld_valid LB, addrLo=2, rdata=0x0080_0000, rd=3 -> mem_writeEnable=1, wrData=0xFFFF_FF80; LHU addrLo=2, rdata=0x8001_0000 -> 0x0000_8001.
REQ-028 SHALL cover: ld_valid and alu_valid (rd=7) same cycle for 3 cycles -> loads written each cycle, ALU queued, alu_ready=0 after 2 accepts, queued results written in order once ld_valid drops.
REQ-029 SHALL cover: alu rd=0, data=0xDEAD -> no enable asserted, wrData unchanged.
REQ-030 SHALL cover: queue holding 2 entries, rst_n pulled low mid-cycle -> enables 0 at once, busy=0, no write of discarded entries after release.
